// File: rtl/dma_pkg.sv
// Shared definitions for the dma block: register map, CTRL bit positions,
// field widths, bus direction encoding and master FSM state encodings.
package dma_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_SRC  = 2'd1;
  localparam logic [1:0] REG_DST  = 2'd2;
  localparam logic [1:0] REG_LEN  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_IE    = 3;
  localparam int CTRL_ABORT = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/dma_master.sv
// Bus-master side of the dma: transfer FSM, word buffer and abort latch.
// DMA_BUS_LOCK_EN keeps the bus between words; otherwise it is re-arbitrated.
//
// state | meaning
// IDLE  | waiting for START
// REQ   | requesting the bus (first cycle after a word is a release gap)
// RD    | source read in flight
// WR    | destination write in flight
// DONE  | one cycle that sets the DONE flag
module dma_master
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              len_zero,
  input  logic              len_one,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic              bus_grnt_,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_,
  output logic              busy,
  output logic              set_done,
  output logic              step,
  output logic              bus_req_,
  output logic              bus_as_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] buffer;
  logic              abort_pend;
  logic              abort_now;
  logic              gap;
  logic              gap_nxt;

  // An abort written on the same edge a write completes must still win.
  assign abort_now = abort_pend | abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      buffer     <= '0;
      abort_pend <= 1'b0;
      gap        <= 1'b0;
    end else begin
      state <= state_nxt;
      gap   <= gap_nxt;
      if (state == ST_RD && !bus_rdy_) begin
        buffer <= bus_rd_data;
      end
      if (state_nxt == ST_IDLE) begin
        abort_pend <= 1'b0;
      end else if (abort && busy) begin
        abort_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_nxt     = 1'b0;
    busy        = 1'b0;
    set_done    = 1'b0;
    step        = 1'b0;
    bus_req_    = 1'b1;
    bus_as_     = 1'b1;
    bus_addr    = '0;
    bus_rw      = RW_READ;
    bus_wr_data = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = len_zero ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        busy     = 1'b1;
        bus_req_ = gap;
        if (abort_now) begin
          state_nxt = ST_IDLE;
        end else if (!gap && !bus_grnt_) begin
          state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        busy     = 1'b1;
        bus_req_ = 1'b0;
        bus_as_  = 1'b0;
        bus_addr = src;
        if (!bus_rdy_) begin
          state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        busy        = 1'b1;
        bus_req_    = 1'b0;
        bus_as_     = 1'b0;
        bus_rw      = RW_WRITE;
        bus_addr    = dst;
        bus_wr_data = buffer;
        if (!bus_rdy_) begin
          step = 1'b1;
          if (len_one) begin
            state_nxt = ST_DONE;
          end else if (abort_now) begin
            state_nxt = ST_IDLE;
          end else begin
`ifdef DMA_BUS_LOCK_EN
            state_nxt = ST_RD;
`else
            state_nxt = ST_REQ;
            gap_nxt   = 1'b1;
`endif
          end
        end
      end
      ST_DONE: begin
        set_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/dma.sv
// Single-channel word DMA: slave register file (CTRL/SRC/DST/LEN) plus the
// dma_master transfer engine. Bus locking is selected with DMA_BUS_LOCK_EN.
module dma
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy_,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_,
  output logic              irq
);

  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              done;
  logic              ie;
  logic [1:0]        idx;
  logic              acc;
  logic              wr_acc;
  logic              ctrl_wr;
  logic              start;
  logic              abort;
  logic              busy;
  logic              set_done;
  logic              step;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_bits;

  assign idx         = addr[1:0];
  // rdy_ low means the previous edge accepted; this keeps each ack one cycle long.
  assign acc         = !cs_ && !as_ && rdy_;
  assign wr_acc      = acc && (rw == RW_WRITE);
  assign ctrl_wr     = wr_acc && (idx == REG_CTRL);
  assign start       = ctrl_wr && wr_data[CTRL_START] && !busy;
  assign abort       = ctrl_wr && wr_data[CTRL_ABORT];
  assign irq         = done & ie;
  assign unused_bits = ^{addr[ADDR_W-1:2], wr_data[DATA_W-1:ADDR_W]};

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_CTRL: begin
        rd_mux[CTRL_BUSY] = busy;
        rd_mux[CTRL_DONE] = done;
        rd_mux[CTRL_IE]   = ie;
      end
      REG_SRC: rd_mux[ADDR_W-1:0] = src;
      REG_DST: rd_mux[ADDR_W-1:0] = dst;
      REG_LEN: rd_mux[LEN_W-1:0]  = len;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_    <= 1'b1;
      rd_data <= '0;
    end else begin
      rdy_    <= !acc;
      rd_data <= (acc && rw == RW_READ) ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src  <= '0;
      dst  <= '0;
      len  <= '0;
      done <= 1'b0;
      ie   <= 1'b0;
    end else begin
      if (step) begin
        src <= src + 30'd1;
        dst <= dst + 30'd1;
        len <= len - 16'd1;
      end else if (wr_acc && !busy) begin
        case (idx)
          REG_SRC: src <= wr_data[ADDR_W-1:0];
          REG_DST: dst <= wr_data[ADDR_W-1:0];
          REG_LEN: len <= wr_data[LEN_W-1:0];
          default: ;
        endcase
      end
      // Hardware completion beats a same-cycle write-1-to-clear.
      if (set_done) begin
        done <= 1'b1;
      end else if (ctrl_wr && wr_data[CTRL_DONE]) begin
        done <= 1'b0;
      end
      if (ctrl_wr) begin
        ie <= wr_data[CTRL_IE];
      end
    end
  end

  dma_master u_master (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .len_zero    (len == '0),
    .len_one     (len == 16'd1),
    .src         (src),
    .dst         (dst),
    .bus_grnt_   (bus_grnt_),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_),
    .busy        (busy),
    .set_done    (set_done),
    .step        (step),
    .bus_req_    (bus_req_),
    .bus_as_     (bus_as_),
    .bus_addr    (bus_addr),
    .bus_rw      (bus_rw),
    .bus_wr_data (bus_wr_data)
  );

endmodule

// File: tb/tb_dma.sv
// Self-checking bench for dma: behavioural bus memory/arbiter, copy model,
// directed cases plus randomized transfers.
`timescale 1ns/1ps
module tb_dma;
  import dma_pkg::*;

`ifdef DMA_BUS_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct {
    logic        w;
    logic [29:0] a;
    logic [31:0] d;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_ = 1'b1;
  logic        as_ = 1'b1;
  logic        rw = 1'b1;
  logic [29:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        bus_req_;
  logic        bus_grnt_ = 1'b1;
  logic        bus_as_;
  logic [29:0] bus_addr;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data = '0;
  logic        bus_rdy_ = 1'b1;
  logic        irq;

  dma dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_addr(bus_addr), .bus_rw(bus_rw),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_miss = 0;

  acc_t        log_q[$];
  acc_t        exp_q[$];
  logic [31:0] bus_mem[logic [29:0]];
  logic [31:0] ref_mem[logic [29:0]];

  int rdy_pct = 100;
  bit hold_rd = 1'b0;
  bit hold_wr = 1'b0;
  int grnt_delay = 0;
  int req_cnt = 0;
  int as_lo_cnt = 0;
  int req_lo_cnt = 0;
  int mon_epoch = 0;
  int last_epoch = 0;
  bit seen_low = 1'b0;
  int hi_run = 0;
  int gaps = 0;
  int max_gap = 0;

  function automatic logic [31:0] bg(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hC3A5_96E1;
  endfunction

  // Bus memory: random ready, logs every completed access.
  always @(negedge clk) begin
    bus_rdy_    = 1'b1;
    bus_rd_data = '0;
    if (reset && !bus_as_ && !(bus_rw == RW_READ ? hold_rd : hold_wr) &&
        ($urandom_range(99) < rdy_pct)) begin
      bus_rdy_ = 1'b0;
      if (bus_rw == RW_READ) begin
        bus_rd_data = bus_mem.exists(bus_addr) ? bus_mem[bus_addr] : bg(bus_addr);
        log_q.push_back('{1'b0, bus_addr, bus_rd_data});
      end else begin
        bus_mem[bus_addr] = bus_wr_data;
        log_q.push_back('{1'b1, bus_addr, bus_wr_data});
      end
    end
  end

  // Arbiter: grant after grnt_delay cycles of request.
  always @(negedge clk) begin
    if (!reset || bus_req_) begin
      bus_grnt_ = 1'b1;
      req_cnt   = 0;
    end else begin
      if (req_cnt >= grnt_delay) bus_grnt_ = 1'b0;
      req_cnt++;
    end
  end

  // Request-release monitor: counts high runs between low periods.
  always @(negedge clk) begin
    if (mon_epoch != last_epoch) begin
      last_epoch = mon_epoch;
      seen_low = 1'b0; hi_run = 0; gaps = 0; max_gap = 0;
    end
    if (!bus_as_) as_lo_cnt++;
    if (!bus_req_) begin
      req_lo_cnt++;
      if (seen_low && hi_run > 0) begin
        gaps++;
        if (hi_run > max_gap) max_gap = hi_run;
      end
      seen_low = 1'b1;
      hi_run = 0;
    end else if (seen_low) begin
      hi_run++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_acc(input bit w, input logic [1:0] idx, input logic [31:0] d,
                         output logic [31:0] q);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0;
    rw = w ? RW_WRITE : RW_READ;
    addr = {28'($urandom), idx};
    wr_data = d;
    @(posedge clk); #1;
    cs_ = 1'b1; as_ = 1'b1;
    q = rd_data;
    if (rdy_ !== 1'b0) rdy_miss++;
    @(posedge clk); #1;
    if (rdy_ !== 1'b1 || rd_data !== 32'h0) rdy_miss++;
  endtask

  task automatic cpu_write(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] q;
    cpu_acc(1'b1, idx, d, q);
  endtask

  task automatic cpu_read(input logic [1:0] idx, output logic [31:0] q);
    cpu_acc(1'b0, idx, 32'h0, q);
  endtask

  function automatic logic [31:0] ctrl_val(input bit busy_v, input bit done_v, input bit ie_v);
    return (32'(ie_v) << 3) | (32'(done_v) << 2) | (32'(busy_v) << 1);
  endfunction

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] q;
    cpu_read(idx, q);
    chk(tag, q, exp);
  endtask

  // Reference copy: word i goes from (s+i) mod 2^30 to (d+i) mod 2^30, in order.
  task automatic model_copy(input logic [29:0] s, input logic [29:0] d, input int n);
    logic [29:0] ra, wa;
    logic [31:0] v;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      ra = 30'((64'(s) + 64'(i)) % 64'h4000_0000);
      wa = 30'((64'(d) + 64'(i)) % 64'h4000_0000);
      v = ref_mem.exists(ra) ? ref_mem[ra] : bg(ra);
      ref_mem[wa] = v;
      exp_q.push_back('{1'b0, ra, v});
      exp_q.push_back('{1'b1, wa, v});
    end
  endtask

  task automatic chk_log(input string tag, input int base);
    chk({tag, "_count"}, 32'(log_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      chk($sformatf("%s_dir%0d", tag, i), 32'(log_q[base+i].w), 32'(exp_q[i].w));
      chk($sformatf("%s_addr%0d", tag, i), 32'(log_q[base+i].a), 32'(exp_q[i].a));
      chk($sformatf("%s_data%0d", tag, i), log_q[base+i].d, exp_q[i].d);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] q;
    int k = 0;
    do begin
      cpu_read(REG_CTRL, q);
      k++;
    end while (q[CTRL_BUSY] && k < 1000);
    chk({tag, "_idle"}, 32'(q[CTRL_BUSY]), 32'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n, input bit ie_v);
    cpu_write(REG_SRC, {2'b10, s});
    cpu_write(REG_DST, {2'b01, d});
    cpu_write(REG_LEN, {16'hBEEF, n});
    cpu_write(REG_CTRL, ctrl_val(1'b0, 1'b1, ie_v));
  endtask

  task automatic wait_access(input bit w, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus_as_ && bus_rw === (w ? RW_WRITE : RW_READ)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_xfer(input string tag, input logic [29:0] s, input logic [29:0] d,
                          input logic [15:0] n, input bit ie_v, input int hold_chk);
    int base, viol;
    setup(s, d, n, ie_v);
    model_copy(s, d, int'(n));
    base = log_q.size();
    mon_epoch++;
    cpu_write(REG_CTRL, ctrl_val(1'b0, 1'b0, ie_v) | 32'h1);
    cpu_write(REG_SRC, $urandom);
    viol = 0;
    for (int k = 0; k < hold_chk; k++) begin
      @(negedge clk);
      if (bus_req_ !== 1'b0 || bus_as_ !== 1'b1) viol++;
    end
    if (hold_chk > 0) chk({tag, "_hold"}, 32'(viol), 32'h0);
    wait_idle(tag);
    chk_log(tag, base);
    chk_reg({tag, "_src"}, REG_SRC, 32'((64'(s) + 64'(n)) % 64'h4000_0000));
    chk_reg({tag, "_dst"}, REG_DST, 32'((64'(d) + 64'(n)) % 64'h4000_0000));
    chk_reg({tag, "_len"}, REG_LEN, 32'h0);
    chk_reg({tag, "_ctrl"}, REG_CTRL, ctrl_val(1'b0, 1'b1, ie_v));
    chk({tag, "_irq"}, 32'(irq), 32'(ie_v));
    if (grnt_delay == 0) begin
      chk({tag, "_gaps"}, 32'(gaps), LOCK ? 32'h0 : 32'(n) - 32'h1);
      chk({tag, "_gapw"}, 32'(max_gap), (LOCK || n < 2) ? 32'h0 : 32'h1);
    end
  endtask

  initial begin
    logic [31:0] r, q;
    logic [29:0] s, d;
    int base, as0, lo0;
    bit ok;

    #2 reset = 1'b0;
    #1;
    chk("rst_req", 32'(bus_req_), 32'h1);
    chk("rst_as", 32'(bus_as_), 32'h1);
    chk("rst_rdy", 32'(rdy_), 32'h1);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    chk_reg("rst_ctrl", REG_CTRL, 32'h0);
    chk_reg("rst_src", REG_SRC, 32'h0);
    chk_reg("rst_len", REG_LEN, 32'h0);

    r = $urandom;
    cpu_write(REG_SRC, r);
    chk_reg("rw_src", REG_SRC, r & 32'h3FFF_FFFF);
    r = $urandom;
    cpu_write(REG_DST, r);
    chk_reg("rw_dst", REG_DST, r & 32'h3FFF_FFFF);
    r = $urandom;
    cpu_write(REG_LEN, r);
    chk_reg("rw_len", REG_LEN, r & 32'h0000_FFFF);

    // Case 1: fixed 3-word copy, immediate grant, single-cycle ready.
    grnt_delay = 0; rdy_pct = 100;
    run_xfer("c1", 30'h100, 30'h200, 16'd3, 1'b1, 0);
    cpu_write(REG_CTRL, ctrl_val(1'b0, 1'b1, 1'b1));
    chk("c1_irq_clr", 32'(irq), 32'h0);
    chk_reg("c1_done_clr", REG_CTRL, ctrl_val(1'b0, 1'b0, 1'b1));

    // Case 2: zero length completes without touching the bus.
    setup(30'h300, 30'h400, 16'd0, 1'b1);
    base = log_q.size();
    lo0 = req_lo_cnt;
    cpu_write(REG_CTRL, ctrl_val(1'b0, 1'b0, 1'b1) | 32'h1);
    chk("c2_irq", 32'(irq), 32'h1);
    repeat (3) @(posedge clk);
    chk("c2_req", 32'(req_lo_cnt - lo0), 32'h0);
    chk("c2_acc", 32'(log_q.size() - base), 32'h0);
    chk_reg("c2_ctrl", REG_CTRL, ctrl_val(1'b0, 1'b1, 1'b1));

    // Case 3: grant withheld for 10 cycles.
    grnt_delay = 10;
    run_xfer("c3", 30'h1000, 30'h2000, 16'd2, 1'b0, 6);
    grnt_delay = 0;

    // Case 4: abort while the first read is stalled.
    s = 30'h0ABC_0000; d = 30'h0DEF_0000;
    setup(s, d, 16'd3, 1'b1);
    model_copy(s, d, 1);
    base = log_q.size();
    hold_rd = 1'b1;
    cpu_write(REG_CTRL, ctrl_val(1'b0, 1'b0, 1'b1) | 32'h1);
    wait_access(1'b0, ok);
    chk("c4_reach_rd", 32'(ok), 32'h1);
    cpu_write(REG_CTRL, ctrl_val(1'b0, 1'b0, 1'b1) | 32'h10);
    hold_rd = 1'b0;
    wait_idle("c4");
    repeat (10) @(posedge clk);
    chk_log("c4", base);
    chk_reg("c4_len", REG_LEN, 32'h2);
    chk_reg("c4_src", REG_SRC, 32'(s) + 32'h1);
    chk_reg("c4_ctrl", REG_CTRL, ctrl_val(1'b0, 1'b0, 1'b1));
    chk("c4_irq", 32'(irq), 32'h0);

    // Case 6: two words, release behaviour between them.
    run_xfer("c6", 30'h3000, 30'h3800, 16'd2, 1'b0, 0);

    // Randomized transfers, the first one wrapping both pointers.
    rdy_pct = 50;
    for (int it = 0; it < 5; it++) begin
      s = (it == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      d = (it == 0) ? 30'h3FFF_FFFF : 30'($urandom);
      grnt_delay = $urandom_range(0, 3);
      run_xfer($sformatf("rnd%0d", it), s, d, 16'($urandom_range(1, 6)), 1'($urandom), 0);
    end
    rdy_pct = 100; grnt_delay = 0;

    // Case 5: reset while a write is stalled.
    setup(30'h5000, 30'h6000, 16'd3, 1'b1);
    hold_wr = 1'b1;
    cpu_write(REG_CTRL, ctrl_val(1'b0, 1'b0, 1'b1) | 32'h1);
    wait_access(1'b1, ok);
    chk("c5_reach_wr", 32'(ok), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("c5_req", 32'(bus_req_), 32'h1);
    chk("c5_as", 32'(bus_as_), 32'h1);
    chk("c5_rw", 32'(bus_rw), 32'(RW_READ));
    chk("c5_addr", 32'(bus_addr), 32'h0);
    chk("c5_wdata", bus_wr_data, 32'h0);
    chk("c5_rdy", 32'(rdy_), 32'h1);
    chk("c5_rdata", rd_data, 32'h0);
    chk("c5_irq", 32'(irq), 32'h0);
    base = log_q.size();
    as0 = as_lo_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hold_wr = 1'b0;
    repeat (20) @(negedge clk);
    chk("c5_no_acc", 32'(log_q.size() - base), 32'h0);
    chk("c5_no_as", 32'(as_lo_cnt - as0), 32'h0);
    chk_reg("c5_ctrl", REG_CTRL, 32'h0);
    chk_reg("c5_len", REG_LEN, 32'h0);
    chk_reg("c5_dst", REG_DST, 32'h0);

    run_xfer("post", 30'($urandom), 30'($urandom), 16'd4, 1'b1, 0);

    chk("rdy_pulse", 32'(rdy_miss), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
